// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response,
// decode-side control inputs and the IF/ID register outputs.
interface instr_fetch_unit_if;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] InstrOut;
  logic [31:0] PcOut;
  logic [31:0] PcPlus4;
  logic        InstrValid;
  logic        Halted;
  logic [15:0] FetchCount;

  modport master (
    output Address,
    input  Instruction,
    input  Stall,
    input  Redirect,
    input  RedirectTarget,
    output InstrOut,
    output PcOut,
    output PcPlus4,
    output InstrValid,
    output Halted,
    output FetchCount
  );

  modport slave (
    input  Address,
    output Instruction,
    output Stall,
    output Redirect,
    output RedirectTarget,
    input  InstrOut,
    input  PcOut,
    input  PcPlus4,
    input  InstrValid,
    input  Halted,
    input  FetchCount
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, ROM address drive, IF/ID capture.
// Ports: Clk, Rst_n (async low), bus (master: ROM + decode signals).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0000_0400,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic Clk,
  input  logic Rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcout_q, pcout_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] redir_pc;

  assign redir_pc = {bus.RedirectTarget[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcout_d = pcout_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.Redirect) begin
          // squash whatever sits in IF/ID, even a stalled slot
          pc_d    = redir_pc;
          valid_d = 1'b0;
          instr_d = NOP_WORD;
        end else if (bus.Stall) begin
          state_d = S_FETCH;
        end else if (pc_q >= MEM_BYTES) begin
          state_d = S_HALT;
          valid_d = 1'b0;
          instr_d = NOP_WORD;
        end else if (bus.Instruction == HALT_WORD) begin
          // PC parks on the halt word; it is never delivered
          state_d = S_HALT;
          valid_d = 1'b0;
          instr_d = NOP_WORD;
        end else begin
          instr_d = bus.Instruction;
          pcout_d = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end
      S_HALT: begin
        if (bus.Redirect) begin
          state_d = S_FETCH;
          pc_d    = redir_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_WORD;
      pcout_q  <= RESET_PC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcout_q  <= pcout_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.Address    = pc_q;
  assign bus.InstrOut   = instr_q;
  assign bus.PcOut      = pcout_q;
  assign bus.PcPlus4    = pcout_q + 32'd4;
  assign bus.InstrValid = valid_q;
  assign bus.Halted     = halted_q;
  assign bus.FetchCount = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed spec scenarios,
// parameter corner instances and randomized scoreboard run.
module tb_instr_fetch_unit;

  localparam logic [31:0] HALT_W = 32'h0000_000C;
  localparam logic [31:0] MEMB   = 32'h0000_0400;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if bw ();
  instr_fetch_unit_if bh ();

  instr_fetch_unit dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bus.master)
  );

  instr_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC),
    .MEM_BYTES(32'hFFFF_FFFF)
  ) dut_w (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bw.master)
  );

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0400)
  ) dut_h (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bh.master)
  );

  logic [31:0] rom [256];

  always_comb begin
    bus.Instruction = 32'h0;
    if (bus.Address < MEMB)
      bus.Instruction = rom[bus.Address[9:2]];
  end

  assign bw.Instruction    = {bw.Address[15:0], 16'h1234};
  assign bw.Stall          = 1'b0;
  assign bw.Redirect       = 1'b0;
  assign bw.RedirectTarget = 32'h0;
  assign bh.Instruction    = 32'h0;
  assign bh.Stall          = 1'b0;
  assign bh.Redirect       = 1'b0;
  assign bh.RedirectTarget = 32'h0;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h",
               nm, act, exp);
    end
  endtask

  // Reference model: architectural view of the fetch unit
  bit          m_started;
  bit          m_halt;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcout;
  bit          m_valid;
  int          m_cnt;

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    return rom[idx];
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_halt    = 0;
    m_pc      = 32'h0;
    m_instr   = 32'h0;
    m_pcout   = 32'h0;
    m_valid   = 0;
    m_cnt     = 0;
  endtask

  task automatic model_edge(input bit st, input bit rd,
                            input logic [31:0] tg);
    logic [31:0] w;
    if (!m_started) begin
      m_started = 1;
    end else if (m_halt) begin
      if (rd) begin
        m_halt = 0;
        m_pc   = tg & 32'hFFFF_FFFC;
      end
    end else if (rd) begin
      m_pc    = tg & 32'hFFFF_FFFC;
      m_valid = 0;
      m_instr = 32'h0;
    end else if (st) begin
      m_valid = m_valid;
    end else if (m_pc >= MEMB) begin
      m_halt  = 1;
      m_valid = 0;
      m_instr = 32'h0;
    end else begin
      w = rom_at(m_pc);
      if (w == HALT_W) begin
        m_halt  = 1;
        m_valid = 0;
        m_instr = 32'h0;
      end else begin
        m_instr = w;
        m_pcout = m_pc;
        m_valid = 1;
        m_pc    = m_pc + 32'd4;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcout;
    logic [31:0] pcp4;
    logic        valid;
    logic        halted;
    logic [15:0] cnt;
  } snap_t;

  snap_t exp_q[$];

  // Monitor: one expected snapshot per clock edge
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_addr",   bus.Address,  e.addr);
        chk("sb_instr",  bus.InstrOut, e.instr);
        chk("sb_pcout",  bus.PcOut,    e.pcout);
        chk("sb_pcp4",   bus.PcPlus4,  e.pcp4);
        chk("sb_valid",  32'(bus.InstrValid), 32'(e.valid));
        chk("sb_halted", 32'(bus.Halted),     32'(e.halted));
        chk("sb_cnt",    32'(bus.FetchCount), 32'(e.cnt));
      end
    end
  end

  // Called at a falling edge; returns at the next falling edge
  task automatic step(input bit st, input bit rd,
                      input logic [31:0] tg);
    snap_t s;
    bus.Stall          = st;
    bus.Redirect       = rd;
    bus.RedirectTarget = tg;
    model_edge(st, rd, tg);
    s.addr   = m_pc;
    s.instr  = m_instr;
    s.pcout  = m_pcout;
    s.pcp4   = m_pcout + 32'd4;
    s.valid  = m_valid;
    s.halted = m_halt;
    s.cnt    = 16'(m_cnt);
    exp_q.push_back(s);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_addr"},   bus.Address,  32'h0);
    chk({nm, "_instr"},  bus.InstrOut, 32'h0);
    chk({nm, "_pcout"},  bus.PcOut,    32'h0);
    chk({nm, "_pcp4"},   bus.PcPlus4,  32'h4);
    chk({nm, "_valid"},  32'(bus.InstrValid), 32'h0);
    chk({nm, "_halted"}, 32'(bus.Halted),     32'h0);
    chk({nm, "_cnt"},    32'(bus.FetchCount), 32'h0);
  endtask

  // Drop reset between edges and check without any clock edge
  task automatic async_rst(input string nm);
    #2 rst_n = 1'b0;
    #1;
    chk_reset(nm);
    bus.Stall    = 1'b0;
    bus.Redirect = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          st, rd;
    logic [31:0] tg;
    rst_n              = 1'b0;
    bus.Stall          = 1'b0;
    bus.Redirect       = 1'b0;
    bus.RedirectTarget = 32'h0;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    rom[0] = 32'h8e68_0021;
    rom[1] = 32'h8e68_0020;
    rom[2] = 32'h2272_0004;
    rom[3] = 32'h0000_000C;
    model_reset();

    @(negedge clk);
    @(negedge clk);
    chk_reset("rst");
    chk("w_rst_addr", bw.Address, 32'hFFFF_FFFC);
    chk("h_rst_addr", bh.Address, 32'h0000_0400);
    rst_n = 1'b1;

    // straight-line fetch of three words
    step(0, 0, 0);
    chk("idle_valid", 32'(bus.InstrValid), 32'h0);
    chk("idle_addr", bus.Address, 32'h0);
    chk("h_idle_halted", 32'(bh.Halted), 32'h0);
    step(0, 0, 0);
    chk("e2_instr", bus.InstrOut, 32'h8e68_0021);
    chk("e2_pcout", bus.PcOut, 32'h0);
    chk("w_pcout", bw.PcOut, 32'hFFFF_FFFC);
    chk("w_wrap_addr", bw.Address, 32'h0);
    chk("w_pcp4", bw.PcPlus4, 32'h0);
    chk("w_valid", 32'(bw.InstrValid), 32'h1);
    chk("h_halted", 32'(bh.Halted), 32'h1);
    chk("h_valid", 32'(bh.InstrValid), 32'h0);
    chk("h_cnt", 32'(bh.FetchCount), 32'h0);
    chk("h_addr", bh.Address, 32'h0000_0400);
    step(0, 0, 0);
    chk("e3_instr", bus.InstrOut, 32'h8e68_0020);
    chk("e3_pcout", bus.PcOut, 32'h4);
    step(0, 0, 0);
    chk("e4_instr", bus.InstrOut, 32'h2272_0004);
    chk("e4_pcout", bus.PcOut, 32'h8);
    chk("e4_cnt", 32'(bus.FetchCount), 32'd3);

    async_rst("arst1");

    // stall, redirect+stall, halt and redirect out of halt
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk("stall_instr", bus.InstrOut, 32'h8e68_0021);
      chk("stall_addr", bus.Address, 32'h4);
      chk("stall_valid", 32'(bus.InstrValid), 32'h1);
    end
    step(0, 0, 0);
    chk("resume_instr", bus.InstrOut, 32'h8e68_0020);
    step(1, 1, 32'h0000_000A);
    chk("redir_addr", bus.Address, 32'h8);
    chk("redir_valid", 32'(bus.InstrValid), 32'h0);
    chk("redir_instr", bus.InstrOut, 32'h0);
    step(0, 0, 0);
    chk("redir_fetch", bus.InstrOut, 32'h2272_0004);
    chk("redir_pcout", bus.PcOut, 32'h8);
    step(0, 0, 0);
    chk("halt_halted", 32'(bus.Halted), 32'h1);
    chk("halt_valid", 32'(bus.InstrValid), 32'h0);
    chk("halt_addr", bus.Address, 32'hC);
    step(1, 0, 0);
    chk("halt_hold", bus.Address, 32'hC);
    step(0, 1, 32'h0);
    chk("unhalt", 32'(bus.Halted), 32'h0);
    chk("unhalt_addr", bus.Address, 32'h0);
    step(0, 0, 0);
    chk("refetch", bus.InstrOut, 32'h8e68_0021);
    chk("refetch_valid", 32'(bus.InstrValid), 32'h1);

    // randomized run against the model
    #2 rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = $urandom;
      if (rom[i] == HALT_W) rom[i] = 32'h1;
      if ($urandom_range(0, 39) == 0) rom[i] = HALT_W;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 700; n++) begin
      if (n == 350) async_rst("arst2");
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) == 0);
      tg = 32'($urandom_range(0, 32'h47F));
      step(st, rd, tg);
    end

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
